bitwise_writeback: RTL and testbench
====================================

BITWISE_WRITEBACK -- requirements
Module: bitwise_writeback

Interface
REQ-001 SHALL have parameter DEST_W, default 5: destination register index width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream bitwise unit result present.
REQ-005 SHALL have port in_ready, output, 1: stage can accept a result this cycle.
REQ-006 SHALL have port in_result, input, 64 (ulong_t): bitwise unit result.
REQ-007 SHALL have port in_carry, input, 1: bitwise unit carry out.
REQ-008 SHALL have port in_size, input, sizeFlags_t: operand size of the result.
REQ-009 SHALL have port in_dest, input, DEST_W: destination register index.
REQ-010 SHALL have port in_flags_we, input, 1: result updates the flags register.
REQ-011 SHALL have port wb_valid, output, 1: buffered entry available to register file.
REQ-012 SHALL have port wb_ready, input, 1: register file consumes the head entry.
REQ-013 SHALL have port wb_data, output, 64: head entry data.
REQ-014 SHALL have port wb_dest, output, DEST_W: head entry destination.
REQ-015 SHALL have port flags, output, 4: {P,N,Z,C}, where P is bit 3.

Function
REQ-016 SHALL hold entries in a 2-entry FIFO with a registered occupancy count of 0..2.
REQ-017 SHALL accept an entry on in_valid && in_ready, and SHALL drive in_ready = (count != 2), registered and not combinationally dependent on wb_ready.
REQ-018 SHALL dequeue the head on wb_valid && wb_ready, with wb_valid = (count != 0).
REQ-019 SHALL give 1-cycle latency: an entry accepted into an empty FIFO at edge N is visible on wb_* after edge N.
REQ-020 SHALL, on simultaneous accept and dequeue, keep count unchanged and preserve FIFO order.
REQ-021 SHALL hold wb_data and wb_dest stable while wb_valid && !wb_ready.
REQ-022 SHALL zero in_result bits at and above the size width before storing (BITS_8: [63:8], BITS_16: [63:16], BITS_32: [63:32]).
REQ-023 SHALL treat any unrecognized in_size value as BITS_64.
REQ-024 SHALL, on accept with in_flags_we=1, update flags at the same edge: C=in_carry; Z=(sized result==0); N=MSB of sized result (bit 7/15/31/63).
REQ-025 SHALL leave flags unchanged on cycles with no accept or with in_flags_we=0.
REQ-026 SHALL make flags independent of FIFO drain order: flags reflect the most recently accepted flag-writing result.
REQ-027 SHALL drop in_valid while in_ready=0 without side effects; upstream holds the result.
REQ-028 SHALL use read/write pointers that wrap modulo 2.

Reset
REQ-029 SHALL, while reset=1, clear count and both pointers, drive wb_valid=0, in_ready=1, flags=4'b0000, wb_data=0 and wb_dest=0.
REQ-030 SHALL, on reset asserted mid-operation, discard buffered entries and ignore same-cycle in_valid and wb_ready.

Configuration
REQ-031 SHALL, with BITWISE_WB_PARITY_EN defined, update flags[3]=P as the even parity of the sized result (P=1 when the count of ones is even), under the rules of REQ-024/025.
REQ-032 SHALL, with BITWISE_WB_PARITY_EN undefined, tie flags[3] to 0 and include no parity logic.

Verification
REQ-033 SHALL cover: reset; then accept result=64'hFF, size=BITS_8, carry=1, we=1, dest=3 -> next cycle wb_valid=1, wb_data=64'hFF, wb_dest=3, flags C=1, N=1, Z=0.
REQ-034 SHALL cover: result=64'h1_0000_0100 with size=BITS_8 -> wb_data=0, Z=1; with size=BITS_16 -> wb_data=64'h100, Z=0.
REQ-035 SHALL cover: wb_ready=0, three back-to-back in_valid with data 1, 2, 3 -> in_ready=0 after two accepts; third held; with wb_ready=1, outputs 1, 2, 3 in order.
REQ-036 SHALL cover: count=1 with simultaneous accept and dequeue every cycle for 10 cycles -> count stays 1, no loss, order preserved.
REQ-037 SHALL cover: accept we=1, result=0, then we=0, result=5 -> flags stay Z=1; macro defined with result=64'h3, BITS_8 -> P=1; macro undefined -> flags[3]=0.
REQ-038 SHALL cover: reset with count=2 -> next cycle wb_valid=0, in_ready=1, flags=0.

Source files
------------

// File: rtl/bitwise_writeback.sv
// Bitwise-unit writeback: 2-entry FIFO to the regfile plus {P,N,Z,C} flags; 1-cycle latency, in_ready = (count != 2) from registered state.
// Optional even-parity flag P is compiled in with BITWISE_WB_PARITY_EN; otherwise flags[3] is tied to 0.
package bitwise_writeback_pkg;
   typedef logic [63:0] ulong_t;
   typedef logic [3:0]  sizeFlags_t;
   localparam sizeFlags_t BITS_8  = 4'b0001;
   localparam sizeFlags_t BITS_16 = 4'b0010;
   localparam sizeFlags_t BITS_32 = 4'b0100;
   localparam sizeFlags_t BITS_64 = 4'b1000;
endpackage

module bitwise_writeback
   import bitwise_writeback_pkg::*;
#(
   parameter int unsigned DEST_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  ulong_t            in_result,
   input  logic              in_carry,
   input  sizeFlags_t        in_size,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              in_flags_we,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [63:0]       wb_data,
   output logic [DEST_W-1:0] wb_dest,
   output logic [3:0]        flags
);

   ulong_t            mem_q  [2];
   ulong_t            mem_d  [2];
   logic [DEST_W-1:0] dest_q [2];
   logic [DEST_W-1:0] dest_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic [2:0]        nzc_q, nzc_d;
   ulong_t            sized_w;
   logic              msb_w;
   logic              accept_w;
   logic              deq_w;

   // Unrecognized size encodings fall through to the full 64-bit width.
   always_comb begin
      sized_w = in_result;
      msb_w   = in_result[63];
      case (in_size)
         BITS_8:  begin sized_w = {56'b0, in_result[7:0]};  msb_w = in_result[7];  end
         BITS_16: begin sized_w = {48'b0, in_result[15:0]}; msb_w = in_result[15]; end
         BITS_32: begin sized_w = {32'b0, in_result[31:0]}; msb_w = in_result[31]; end
         default: ;
      endcase
   end

   // Reset overrides the visible handshake so same-cycle traffic is ignored.
   assign wb_valid = !reset && (count_q != 2'd0);
   assign in_ready = reset || (count_q != 2'd2);
   assign accept_w = in_valid && in_ready && !reset;
   assign deq_w    = wb_valid && wb_ready;
   assign wb_data  = reset ? 64'b0 : mem_q[rd_ptr_q];
   assign wb_dest  = reset ? '0 : dest_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      dest_d   = dest_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      nzc_d    = nzc_q;
      count_d  = count_q + {1'b0, accept_w} - {1'b0, deq_w};
      if (accept_w) begin
         mem_d[wr_ptr_q]  = sized_w;
         dest_d[wr_ptr_q] = in_dest;
         wr_ptr_d         = ~wr_ptr_q;
         if (in_flags_we) begin
            nzc_d = {msb_w, (sized_w == 64'b0), in_carry};
         end
      end
      if (deq_w) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         dest_q[0] <= '0;
         dest_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         nzc_q     <= 3'b0;
      end else begin
         mem_q    <= mem_d;
         dest_q   <= dest_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         nzc_q    <= nzc_d;
      end
   end

`ifdef BITWISE_WB_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (accept_w && in_flags_we) begin
         par_d = ~^sized_w;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign flags = reset ? 4'b0 : {par_q, nzc_q};
`else
   assign flags = reset ? 4'b0 : {1'b0, nzc_q};
`endif

endmodule

// File: tb/tb_bitwise_writeback.sv
// Directed self-checking bench for bitwise_writeback (default DEST_W).
module tb_bitwise_writeback;
   import bitwise_writeback_pkg::*;

`ifdef BITWISE_WB_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   ulong_t      in_result;
   logic        in_carry;
   sizeFlags_t  in_size;
   logic [4:0]  in_dest;
   logic        in_flags_we;
   logic        wb_valid;
   logic        wb_ready;
   logic [63:0] wb_data;
   logic [4:0]  wb_dest;
   logic [3:0]  flags;

   int checks   = 0;
   int failures = 0;

   bitwise_writeback #(.DEST_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_size(in_size),
      .in_dest(in_dest), .in_flags_we(in_flags_we),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_data(wb_data), .wb_dest(wb_dest), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] r, input sizeFlags_t s, input logic c,
                       input logic we, input logic [4:0] d);
      in_valid    = 1'b1;
      in_result   = r;
      in_size     = s;
      in_carry    = c;
      in_flags_we = we;
      in_dest     = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
      in_size = BITS_64; in_dest = '0; in_flags_we = 1'b0; wb_ready = 1'b0;
      tick(); tick();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flags",    flags,    0);
      chk("rst_wb_data",  wb_data,  0);
      chk("rst_wb_dest",  wb_dest,  0);
      reset = 1'b0;
      tick();

      // Basic accept: byte result with carry
      push(64'hFF, BITS_8, 1'b1, 1'b1, 5'd3);
      chk("t1_wb_valid", wb_valid, 1);
      chk("t1_wb_data",  wb_data,  64'hFF);
      chk("t1_wb_dest",  wb_dest,  3);
      chk("t1_flags",    flags,    {PAR_EN, 3'b101});
      pop();
      chk("t1_drained", wb_valid, 0);

      // Size masking
      push(64'h1_0000_0100, BITS_8, 1'b0, 1'b1, 5'd1);
      chk("t2_b8_data",  wb_data, 0);
      chk("t2_b8_flags", flags,   {PAR_EN, 3'b010});
      pop();
      push(64'h1_0000_0100, BITS_16, 1'b0, 1'b1, 5'd2);
      chk("t2_b16_data",  wb_data, 64'h100);
      chk("t2_b16_flags", flags,   4'b0000);
      pop();
      push(64'hFFFF_FFFF_8000_0000, BITS_32, 1'b0, 1'b1, 5'd4);
      chk("t2_b32_data",  wb_data, 64'h8000_0000);
      chk("t2_b32_flags", flags,   4'b0100);
      pop();
      push(64'h8000_0000_0000_0001, 4'b0000, 1'b1, 1'b1, 5'd5);
      chk("t2_unk_data",  wb_data, 64'h8000_0000_0000_0001);
      chk("t2_unk_flags", flags,   {PAR_EN, 3'b101});
      pop();

      // Back-pressure: third result held while full
      wb_ready = 1'b0;
      in_valid = 1'b1; in_flags_we = 1'b0; in_size = BITS_64; in_dest = 5'd7;
      in_result = 64'd1;
      tick();
      chk("t3_rdy_after1", in_ready, 1);
      in_result = 64'd2;
      tick();
      chk("t3_rdy_after2", in_ready, 0);
      in_result = 64'd3;
      tick();
      chk("t3_rdy_held", in_ready, 0);
      chk("t3_head1",    wb_data,  64'd1);
      wb_ready = 1'b1;
      tick();
      chk("t3_head2", wb_data, 64'd2);
      tick();
      chk("t3_head3", wb_data, 64'd3);
      in_valid = 1'b0;
      tick();
      chk("t3_empty", wb_valid, 0);
      wb_ready = 1'b0;

      // Simultaneous accept and dequeue at count=1
      push(64'd100, BITS_64, 1'b0, 1'b0, 5'd9);
      for (int i = 0; i < 10; i++) begin
         chk("t4_order", wb_data, 64'(100 + i));
         in_valid  = 1'b1;
         in_result = 64'(101 + i);
         wb_ready  = 1'b1;
         tick();
         chk("t4_valid", wb_valid, 1);
         chk("t4_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      wb_ready = 1'b0;
      chk("t4_last", wb_data, 64'd110);
      pop();
      chk("t4_empty", wb_valid, 0);

      // Flag write enable and parity
      push(64'd0, BITS_64, 1'b0, 1'b1, 5'd1);
      chk("t5_zero_flags", flags, {PAR_EN, 3'b010});
      pop();
      push(64'd5, BITS_64, 1'b1, 1'b0, 5'd1);
      chk("t5_we0_flags", flags, {PAR_EN, 3'b010});
      pop();
      push(64'h3, BITS_8, 1'b0, 1'b1, 5'd1);
      chk("t5_par_flags", flags,    {PAR_EN, 3'b000});
      chk("t5_par_bit",   flags[3], PAR_EN);
      pop();

      // Reset while full, with same-cycle traffic
      push(64'hFF, BITS_8, 1'b1, 1'b1, 5'd2);
      push(64'hFF, BITS_8, 1'b1, 1'b1, 5'd3);
      chk("t6_full", in_ready, 0);
      reset = 1'b1; in_valid = 1'b1; wb_ready = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
      chk("t6_wb_valid", wb_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_flags",    flags,    0);
      chk("t6_wb_data",  wb_data,  0);
      tick();
      chk("t6_still_empty", wb_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
